// File: rtl/charchk_pkg.sv
// Shared constants and state encoding for the cyclic character checker.
// Active-level constants, default sequence bounds and tracker states.
package charchk_pkg;

    localparam logic N_T = 1'b0;
    localparam logic N_F = 1'b1;

    localparam logic [7:0] FIRSTCHAR_DEF = 8'h61;
    localparam logic [7:0] LASTCHAR_DEF  = 8'h7a;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // Successor in the cyclic sequence; the wrap check wins over +1.
    function automatic logic [7:0] seq_succ(
        input logic [7:0] c,
        input logic [7:0] first,
        input logic [7:0] last
    );
        return (c == last) ? first : c + 8'd1;
    endfunction

endpackage

// File: rtl/charchk.sv
// Cyclic character sequence checker fed from a show-ahead FIFO.
// Define CHARCHK_STOP_ON_ERR_EN to halt on the first tracking mismatch.
module charchk
    import charchk_pkg::*;
#(
    parameter logic [7:0] LASTCHAR  = LASTCHAR_DEF,
    parameter logic [7:0] FIRSTCHAR = FIRSTCHAR_DEF
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  port,
    input  logic        n_cs,
    output logic        n_rd,
    output logic        n_lock,
    output logic        n_err,
    output logic [15:0] err_cnt,
    output logic [15:0] rx_cnt
);

    state_e      state_q, state_d;
    logic [7:0]  exp_q, exp_d;
    logic        rd_en_q, rd_en_d;
    logic        n_err_q, n_err_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic        acc;

    // Pop only a non-empty FIFO, never in HALT, never while in reset.
    assign n_rd    = (!n_cs && rd_en_q && n_rst) ? N_T : N_F;
    assign acc     = (n_rd == N_T);
    assign n_lock  = (state_q == ST_TRACK) ? N_T : N_F;
    assign n_err   = n_err_q;
    assign err_cnt = err_cnt_q;
    assign rx_cnt  = rx_cnt_q;

    // Next-state, expected byte and counter updates on an accepted byte.
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        n_err_d   = n_err_q;
        err_cnt_d = err_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        if (acc) begin
            rx_cnt_d = rx_cnt_q + 16'd1;
            unique case (state_q)
                ST_HUNT: begin
                    if (port == FIRSTCHAR) begin
                        state_d = ST_TRACK;
                        exp_d   = seq_succ(FIRSTCHAR, FIRSTCHAR, LASTCHAR);
                    end
                end
                ST_TRACK: begin
                    if (port == exp_q) begin
                        exp_d = seq_succ(exp_q, FIRSTCHAR, LASTCHAR);
                    end else begin
                        n_err_d = N_T;
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
`ifdef CHARCHK_STOP_ON_ERR_EN
                        state_d = ST_HALT;
                        exp_d   = FIRSTCHAR;
`else
                        if (port == FIRSTCHAR) begin
                            state_d = ST_TRACK;
                            exp_d   = seq_succ(FIRSTCHAR, FIRSTCHAR, LASTCHAR);
                        end else begin
                            state_d = ST_HUNT;
                            exp_d   = FIRSTCHAR;
                        end
`endif
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Read enable is registered so HALT closes the pop gate next cycle.
    always_comb begin
        rd_en_d = (state_d != ST_HALT);
    end

    // State, expected byte, sticky error flag and counters.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_HUNT;
            exp_q     <= FIRSTCHAR;
            rd_en_q   <= 1'b1;
            n_err_q   <= N_F;
            err_cnt_q <= 16'd0;
            rx_cnt_q  <= 16'd0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            rd_en_q   <= rd_en_d;
            n_err_q   <= n_err_d;
            err_cnt_q <= err_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
        end
    end

endmodule

// File: doc/charchk.md
CHARCHK -- requirements
Module: charchk

Interface
REQ-001 Parameter LASTCHAR, default "z": last character of the expected cyclic sequence.
REQ-002 Parameter FIRSTCHAR, default "a": first character of the sequence; the successor of LASTCHAR.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 n_rst  input  1  asynchronous, active-low reset.
REQ-005 port  input  8  FIFO head byte (show-ahead); valid whenever n_cs is low.
REQ-006 n_cs  input  1  active-low FIFO not-empty indication.
REQ-007 n_rd  output  1  active-low pop strobe to FIFO.
REQ-008 n_lock  output  1  active-low; sequence tracker is locked.
REQ-009 n_err  output  1  active-low sticky error flag.
REQ-010 err_cnt  output  16  count of mismatched bytes.
REQ-011 rx_cnt  output  16  count of accepted bytes.

Function
REQ-012 A byte SHALL be accepted at a rising edge where n_cs and n_rd are both low; no other edge consumes a byte.
REQ-013 n_rd SHALL be low only in cycles where n_cs is low and the state is not HALT (combinational gate of n_cs with a registered enable), so an empty FIFO is never popped.
REQ-014 Zero-latency read: the checker SHALL sample port at the same edge the byte is accepted; back-to-back acceptance every cycle SHALL be supported.
REQ-015 State HUNT: accepted bytes other than FIRSTCHAR SHALL be discarded without error; FIRSTCHAR SHALL set expected = FIRSTCHAR+1 and move to TRACK.
REQ-016 State TRACK: accepted byte equal to expected SHALL advance expected (LASTCHAR wraps to FIRSTCHAR); n_lock SHALL be low in TRACK only.
REQ-017 TRACK mismatch SHALL increment err_cnt, drive n_err low (sticky until reset), and transition per REQ-024/025.
REQ-018 rx_cnt SHALL increment on every accepted byte in any state, wrapping at 16'hFFFF to 0.
REQ-019 err_cnt SHALL saturate at 16'hFFFF.
REQ-020 Expected-value arithmetic SHALL be 8-bit; comparison with LASTCHAR SHALL take priority over increment.
REQ-021 n_cs rising mid-stream SHALL stall tracking with state and expected value held.

Reset
REQ-022 Asynchronous n_rst low SHALL immediately force: state HUNT, n_rd high, n_lock high, n_err high, err_cnt 0, rx_cnt 0, expected FIRSTCHAR.
REQ-023 Reset asserted mid-transfer SHALL abort; the byte at that edge is not accepted.

Configuration
REQ-024 With CHARCHK_STOP_ON_ERR_EN defined: a TRACK mismatch SHALL enter HALT; in HALT n_rd stays high until reset.
REQ-025 Without CHARCHK_STOP_ON_ERR_EN: a mismatch SHALL return to HUNT; if the mismatched byte is FIRSTCHAR it SHALL relock directly to TRACK with expected FIRSTCHAR+1.

Structure
REQ-026 Active-level constants (nT/nF), FIRSTCHAR default and state encodings SHALL live in the shared common.v header, shared with chargen.
REQ-027 No sub-module; single module with one state register, expected register and two counters.

Verification
REQ-028 Reset then FIFO feeding "a".."z","a","b" back-to-back -> n_lock low after first "a", err_cnt 0, rx_cnt 28, n_err high.
REQ-029 Feed "x","y","a","b" -> first two discarded, n_lock low after "a", err_cnt 0, rx_cnt 4.
REQ-030 Locked, feed "c","e" (expected "d") -> err_cnt 1, n_err low; without macro n_lock high next cycle; with macro n_rd stays high though n_cs low.
REQ-031 n_cs toggles high every other cycle during "a".."f" -> n_rd never low while n_cs high, no errors, rx_cnt 6.
REQ-032 Assert n_rst mid-stream at "m" -> outputs return to reset values asynchronously; resumes in HUNT on release.
REQ-033 Force 70000 mismatches (macro off) -> err_cnt holds 16'hFFFF, rx_cnt wrapped.
